if_prefetch: RTL and testbench

Parametrised instruction-fetch stage that keeps up to DEPTH instruction requests in flight on the SRAM-like instruction bus. Returned words are buffered in an in-order queue with their PCs and handed to decode over a valid/ready handshake. Sits between the PC-redirect logic (branch/jump/EPC/exception) and the decode stage, replacing the single-request fetch with stall-by-bus behaviour.

---
 rtl/if_prefetch_if.sv | 24 ++
 rtl/if_prefetch.sv | 159 +++++++++++++++
 tb/tb_if_prefetch.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_prefetch_if.sv
// if_prefetch_if: SRAM-like instruction bus between the fetch stage (master) and the bus bridge (slave).
// Requests are accepted with inst_addr_ok; data returns in order with inst_data_ok.
interface if_prefetch_if #(
  parameter int WIDTH = 32
);
  logic             inst_req;
  logic             inst_wr;
  logic [1:0]       inst_size;
  logic [WIDTH-1:0] inst_addr;
  logic [WIDTH-1:0] inst_wdata;
  logic [WIDTH-1:0] inst_rdata;
  logic             inst_addr_ok;
  logic             inst_data_ok;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_rdata, inst_addr_ok, inst_data_ok
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_rdata, inst_addr_ok, inst_data_ok
  );
endinterface

// File: rtl/if_prefetch.sv
// if_prefetch: instruction fetch stage keeping up to DEPTH requests in flight, with an in-order return queue.
// Define IF_ADDR_CHECK_EN to turn misaligned fetch PCs into AdEL queue entries instead of masked bus requests.
module if_prefetch #(
  parameter int               WIDTH      = 32,
  parameter int               DEPTH      = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'hbfc0_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'hbfc0_0380
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             exc_valid,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr,
  output logic             out_adel,
  output logic             busy,
  if_prefetch_if.master    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] req_addr;
  logic             req_stale;
  logic [WIDTH-1:0] pc_q    [DEPTH];
  logic [WIDTH-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0] filled_q;
  logic [PW-1:0]    head, tail, fill_ptr;
  logic [CW-1:0]    count, pend, discard;

  logic          flush, accept, acc_live, acc_dead, drop, fill, pop;
  logic          credit, issue_slot, good_issue, bad_issue;
  logic [CW-1:0] count_after, discard_after;
  logic [CW:0]   credit_sum;

  assign flush    = exc_valid | redirect_valid;
  assign accept   = (state == REQ) & bus.inst_addr_ok;
  assign acc_live = accept & ~req_stale & ~flush;
  assign acc_dead = accept & (req_stale | flush);
  assign drop     = bus.inst_data_ok & (discard != '0);
  assign fill     = bus.inst_data_ok & (discard == '0) & (pend != '0);
  assign pop      = out_valid & out_ready;

  assign count_after   = count + CW'(acc_live) - CW'(pop);
  assign discard_after = discard + CW'(acc_dead) - CW'(drop);
  // Responses still owed for flushed requests occupy bus slots, so they consume credit too
  assign credit_sum    = {1'b0, count_after} + {1'b0, discard_after};
  assign credit        = int'(credit_sum) < DEPTH;
  assign issue_slot    = ~flush & credit & ((state == IDLE) | accept);

`ifdef IF_ADDR_CHECK_EN
  logic [DEPTH-1:0] adel_q;
  logic             halted;
  assign bad_issue  = issue_slot & ~halted & (fetch_pc[1:0] != 2'b00);
  assign good_issue = issue_slot & ~halted & (fetch_pc[1:0] == 2'b00);
  assign out_adel   = adel_q[head];
`else
  assign bad_issue  = 1'b0;
  assign good_issue = issue_slot;
  assign out_adel   = 1'b0;
`endif

  assign out_valid      = filled_q[head];
  assign out_pc         = pc_q[head];
  assign out_instr      = instr_q[head];
  assign busy           = (state == REQ) | (pend != '0) | (discard != '0);
  assign bus.inst_req   = (state == REQ);
  assign bus.inst_wr    = 1'b0;
  assign bus.inst_size  = 2'b10;
  assign bus.inst_addr  = req_addr;
  assign bus.inst_wdata = '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      req_addr  <= '0;
      req_stale <= 1'b0;
      filled_q  <= '0;
      head      <= '0;
      tail      <= '0;
      fill_ptr  <= '0;
      count     <= '0;
      pend      <= '0;
      discard   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
`ifdef IF_ADDR_CHECK_EN
      adel_q <= '0;
      halted <= 1'b0;
`endif
    end else begin
      if (fill) begin
        instr_q[fill_ptr]  <= bus.inst_rdata;
        filled_q[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + 1'b1;
      end
      if (pop) begin
        filled_q[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (acc_live) begin
        pc_q[tail]     <= req_addr;
        filled_q[tail] <= 1'b0;
      end
`ifdef IF_ADDR_CHECK_EN
      if (pop) adel_q[head] <= 1'b0;
      if (acc_live) adel_q[tail] <= 1'b0;
      // The AdEL entry lands behind any request accepted in the same cycle
      if (bad_issue) begin
        pc_q[tail + PW'(acc_live)]     <= fetch_pc;
        instr_q[tail + PW'(acc_live)]  <= '0;
        filled_q[tail + PW'(acc_live)] <= 1'b1;
        adel_q[tail + PW'(acc_live)]   <= 1'b1;
        halted                         <= 1'b1;
      end
`endif
      tail    <= tail + PW'(acc_live) + PW'(bad_issue);
      count   <= count_after + CW'(bad_issue);
      pend    <= pend + CW'(acc_live) - CW'(fill);
      discard <= discard_after;

      if (good_issue) begin
        state    <= REQ;
        req_addr <= {fetch_pc[WIDTH-1:2], 2'b00};
        fetch_pc <= fetch_pc + WIDTH'(4);
      end else if (accept) begin
        state <= IDLE;
      end

      // A flushed request stays on the bus until accepted, then its response is discarded
      if (accept) req_stale <= 1'b0;
      else if (flush && state == REQ) req_stale <= 1'b1;

      if (flush) begin
        fetch_pc <= exc_valid ? EXC_VECTOR : redirect_pc;
        filled_q <= '0;
        head     <= '0;
        tail     <= '0;
        fill_ptr <= '0;
        count    <= '0;
        pend     <= '0;
        discard  <= discard_after + pend - CW'(fill);
`ifdef IF_ADDR_CHECK_EN
        adel_q <= '0;
        halted <= 1'b0;
`endif
      end
    end
  end
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: scoreboard bench for if_prefetch driving an in-order bus model with configurable data latency.
// Build with IF_ADDR_CHECK_EN defined to exercise the misaligned-fetch entry instead of address masking.
module tb_if_prefetch;
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic        exc_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] redirect_pc = '0;
  logic        out_valid, out_adel, busy;
  logic [31:0] out_pc, out_instr;

  always #5 clk = ~clk;

  if_prefetch_if #(.WIDTH(32)) bif ();

  if_prefetch #(.WIDTH(32), .DEPTH(4), .RESET_PC(32'hbfc0_0000), .EXC_VECTOR(32'hbfc0_0380)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .exc_valid(exc_valid), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_adel(out_adel), .busy(busy), .bus(bif)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  typedef struct { logic [31:0] addr; int due; } bus_t;

  exp_t exp_q[$];
  bus_t bq[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lat = 1;
  int   hs_count = 0;
  logic addr_en = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hc3a5_5a3c;
  endfunction

  assign bif.inst_addr_ok = bif.inst_req & addr_en;

  // Bus model: an accepted request in cycle c returns its word in cycle c+lat, in order
  always @(posedge clk) begin
    if (rst) begin
      bq.delete();
      bif.inst_data_ok <= 1'b0;
      bif.inst_rdata   <= '0;
      cyc              <= 0;
      hs_count         <= 0;
    end else begin
      bus_t p;
      if (bif.inst_req && bif.inst_addr_ok) begin
        p.addr = bif.inst_addr;
        p.due  = cyc + lat;
        bq.push_back(p);
        hs_count <= hs_count + 1;
      end
      if (bq.size() > 0 && bq[0].due <= cyc + 1) begin
        bif.inst_data_ok <= 1'b1;
        bif.inst_rdata   <= mem_word(bq[0].addr);
        void'(bq.pop_front());
      end else begin
        bif.inst_data_ok <= 1'b0;
        bif.inst_rdata   <= '0;
      end
      cyc <= cyc + 1;
    end
  end

  task automatic apply_reset();
    rst = 1'b1; redirect_valid = 1'b0; exc_valid = 1'b0; redirect_pc = '0;
    out_ready = 1'b1; addr_en = 1'b1; lat = 1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.pc    = start + 32'(4 * k);
      e.instr = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("[TB] FAIL rst_out_pc: got %h want 0", out_pc); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("[TB] FAIL rst_out_instr: got %h want 0", out_instr); end
    total++; if (out_adel !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_adel: got %b want 0", out_adel); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", busy); end
    total++; if (bif.inst_req !== 1'b0) begin bad++; $display("[TB] FAIL rst_inst_req: got %b want 0", bif.inst_req); end
    total++; if (bif.inst_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_inst_addr: got %h want 0", bif.inst_addr); end
    total++; if (bif.inst_size !== 2'b10 || bif.inst_wr !== 1'b0) begin bad++; $display("[TB] FAIL rst_size_wr: got %b/%b want 10/0", bif.inst_size, bif.inst_wr); end
    rst = 1'b0;
    @(negedge clk);
    total++; if (bif.inst_req !== 1'b1 || bif.inst_addr !== RESET_PC) begin bad++; $display("[TB] FAIL first_req: got %b/%h want 1/%h", bif.inst_req, bif.inst_addr, RESET_PC); end
  endtask

  task automatic test_stream();
    exp_t e; logic [31:0] exp_addr; int first; int gaps;
    apply_reset();
    push_stream(RESET_PC, 12);
    exp_addr = RESET_PC; first = -1; gaps = 0;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bif.inst_req && bif.inst_addr_ok) begin
        total++;
        if (bif.inst_addr !== exp_addr) begin bad++; $display("[TB] FAIL stream_addr: got %h want %h", bif.inst_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); total++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin bad++; $display("[TB] FAIL stream_word: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr); end
        if (first < 0) first = c;
      end else if (first >= 0) gaps++;
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL stream_timeout: got %0d left want 0", exp_q.size()); end
    total++; if (gaps !== 0) begin bad++; $display("[TB] FAIL stream_gaps: got %0d want 0", gaps); end
  endtask

  task automatic test_stall();
    exp_t e;
    apply_reset();
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    total++; if (hs_count !== 4) begin bad++; $display("[TB] FAIL stall_handshakes: got %0d want 4", hs_count); end
    total++; if (bif.inst_req !== 1'b0) begin bad++; $display("[TB] FAIL stall_req_low: got %b want 0", bif.inst_req); end
    push_stream(RESET_PC, 8);
    out_ready = 1'b1;
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); total++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin bad++; $display("[TB] FAIL stall_word: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr); end
      end
      @(negedge clk);
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL stall_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect_flush();
    exp_t e; int c;
    apply_reset();
    lat = 3;
    for (c = 0; c < 20 && hs_count < 2; c++) begin
      @(negedge clk);
      if (out_valid) begin total++; bad++; $display("[TB] FAIL redir_early: got pc %h want none", out_pc); end
    end
    total++; if (hs_count !== 2) begin bad++; $display("[TB] FAIL redir_setup: got %0d handshakes want 2", hs_count); end
    addr_en = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    push_stream(32'h8000_1000, 6);
    @(negedge clk);
    redirect_valid = 1'b0; addr_en = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL redir_busy: got %b want 1", busy); end
    for (c = 0; c < 60 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); total++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin bad++; $display("[TB] FAIL redir_word: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL redir_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_exc_priority();
    exp_t e;
    apply_reset();
    exc_valid = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    push_stream(32'hbfc0_0380, 4);
    @(negedge clk);
    exc_valid = 1'b0; redirect_valid = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); total++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin bad++; $display("[TB] FAIL exc_word: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL exc_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    exp_t e; logic [31:0] exp_addr;
    apply_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hffff_fff8;
    push_stream(32'hffff_fff8, 4);
    exp_addr = 32'hffff_fff8;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int c = 0; c < 30 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (bif.inst_req && bif.inst_addr_ok && exp_addr != 32'h0000_0008) begin
        total++;
        if (bif.inst_addr !== exp_addr) begin bad++; $display("[TB] FAIL wrap_addr: got %h want %h", bif.inst_addr, exp_addr); end
        exp_addr = exp_addr + 32'd4;
      end
      if (out_valid && out_ready) begin
        e = exp_q.pop_front(); total++;
        if (out_pc !== e.pc || out_instr !== e.instr) begin bad++; $display("[TB] FAIL wrap_word: got %h/%h want %h/%h", out_pc, out_instr, e.pc, e.instr); end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL wrap_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_misaligned();
    apply_reset();
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0002;
    @(negedge clk);
    redirect_valid = 1'b0;
`ifdef IF_ADDR_CHECK_EN
    begin
      int seen_req;
      seen_req = 0;
      repeat (4) begin
        @(negedge clk);
        if (bif.inst_req) seen_req++;
      end
      total++; if (seen_req !== 0) begin bad++; $display("[TB] FAIL adel_no_req: got %0d req cycles want 0", seen_req); end
      total++; if (out_valid !== 1'b1 || out_adel !== 1'b1) begin bad++; $display("[TB] FAIL adel_flags: got %b/%b want 1/1", out_valid, out_adel); end
      total++; if (out_pc !== 32'h8000_0002 || out_instr !== 32'h0) begin bad++; $display("[TB] FAIL adel_entry: got %h/%h want 80000002/0", out_pc, out_instr); end
    end
`else
    @(negedge clk);
    total++; if (bif.inst_req !== 1'b1 || bif.inst_addr !== 32'h8000_0000) begin bad++; $display("[TB] FAIL mask_addr: got %b/%h want 1/80000000", bif.inst_req, bif.inst_addr); end
    repeat (3) @(negedge clk);
    total++; if (out_valid !== 1'b1 || out_adel !== 1'b0) begin bad++; $display("[TB] FAIL mask_adel: got %b/%b want 1/0", out_valid, out_adel); end
`endif
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_flush();
    test_exc_priority();
    test_wrap();
    test_misaligned();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
